// File: rtl/core_fetch.sv
// Instruction fetch stage: owns the PC and issues in-order requests over a request/grant bus.
// Returned words are buffered and presented to decode one per cycle, with stall and redirect/flush support.
`timescale 1ns/1ps
module core_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] INST,
    output logic [31:0] INST_PC,
    output logic        INST_VALID
);

    localparam int          PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW  = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];

    logic        grant;
    logic        resp_valid;
    logic        resp_keep;
    logic        fifo_empty;
    logic        write_through;
    logic        do_push;
    logic        do_pop;
    logic        push_en;
    logic [31:0] redirect_target;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit covers both buffered words and in-flight requests, so the FIFO can never overflow.
    assign redirect_target = REDIRECT_PC & ~32'd3;
    assign fifo_empty      = (fifo_count == '0);
    assign IMEM_REQ        = !RST && !REDIRECT && ((fifo_count + outstanding) < CW'(FIFO_DEPTH));
    assign IMEM_ADDR       = pc;
    assign grant           = IMEM_REQ && IMEM_GNT;
    assign resp_valid      = IMEM_RVALID && (outstanding != '0);
    assign resp_keep       = resp_valid && (drop_cnt == '0);
    assign write_through   = resp_keep && fifo_empty && !STALL;
    assign do_pop          = !STALL && !fifo_empty;
    assign do_push         = resp_keep && !write_through;
    assign push_en         = !RST && !REDIRECT && do_push;

    always_ff @(posedge CLK) begin
        if (push_en) begin
            fifo_inst[wr_ptr] <= IMEM_RDATA;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

    // resp_pc tracks the PC of the next kept response; dropped old-path words never advance it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            INST        <= NOP;
            INST_PC     <= 32'h0;
            INST_VALID  <= 1'b0;
        end else if (REDIRECT) begin
            pc          <= redirect_target;
            resp_pc     <= redirect_target;
            outstanding <= outstanding - CW'(resp_valid);
            drop_cnt    <= outstanding - CW'(resp_valid);
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            INST        <= NOP;
            INST_PC     <= redirect_target;
            INST_VALID  <= 1'b0;
        end else begin
            if (grant) begin
                pc <= pc + 32'd4;
            end
            outstanding <= outstanding + CW'(grant) - CW'(resp_valid);
            if (resp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (resp_keep) begin
                resp_pc <= resp_pc + 32'd4;
            end
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            fifo_count <= fifo_count + CW'(do_push) - CW'(do_pop);
            if (!STALL) begin
                if (do_pop) begin
                    INST       <= fifo_inst[rd_ptr];
                    INST_PC    <= fifo_pc[rd_ptr];
                    INST_VALID <= 1'b1;
                end else if (write_through) begin
                    INST       <= IMEM_RDATA;
                    INST_PC    <= resp_pc;
                    INST_VALID <= 1'b1;
                end else begin
                    INST       <= NOP;
                    INST_VALID <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_core_fetch.sv
// Scoreboard bench for core_fetch: an in-order memory model answers grants, and a path model predicts
// the instruction stream decode should consume (sequential PCs restarting at each redirect).
`timescale 1ns/1ps
module tb_core_fetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        STALL;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic [31:0] INST;
    logic [31:0] INST_PC;
    logic        INST_VALID;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t  exp_q [$];
    pend_t pend_q[$];

    int          n_checks   = 0;
    int          n_fails    = 0;
    int          cycle      = 0;
    int          lat_min    = 1;
    int          lat_max    = 1;
    int          grant_cnt  = 0;
    int          n_consumed = 0;
    bit          saw_wrap   = 0;
    logic [31:0] last_pc    = 32'h0;
    exp_t        mon_e;

    core_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .INST(INST), .INST_PC(INST_PC), .INST_VALID(INST_VALID)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        return addr | 32'h1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // The predicted program path: sequential words from start, wrapping modulo 2^32.
    task automatic resetModel(input logic [31:0] start);
        logic [31:0] a;
        exp_q.delete();
        a = start;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back('{pc: a, inst: inst_of(a)});
            a = a + 32'd4;
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit gnt, input bit stall, input bit redir,
                                 input logic [31:0] rpc);
        pend_t p;
        @(posedge CLK);
        #1;
        cycle++;
        RST         = rst;
        IMEM_GNT    = gnt;
        STALL       = stall;
        REDIRECT    = redir;
        REDIRECT_PC = rpc;
        IMEM_RVALID = 1'b0;
        IMEM_RDATA  = $urandom;
        if (rst) begin
            pend_q.delete();
            resetModel(RESET_PC);
        end else begin
            if (redir) resetModel(rpc & ~32'd3);
            if (pend_q.size() > 0 && pend_q[0].due <= cycle) begin
                p           = pend_q.pop_front();
                IMEM_RVALID = 1'b1;
                IMEM_RDATA  = inst_of(p.addr);
            end
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_inst", INST, NOP);
        checkOutput("rst_inst_valid", {31'd0, INST_VALID}, 32'd0);
        checkOutput("rst_inst_pc", INST_PC, 32'h0);
        checkOutput("rst_imem_req", {31'd0, IMEM_REQ}, 32'd0);
    endtask

    // Monitor: logs grants into the memory model and consumes instructions decode would accept.
    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            if (IMEM_REQ && IMEM_GNT) begin
                checkOutput("imem_addr_aligned", {30'd0, IMEM_ADDR[1:0]}, 32'd0);
                pend_q.push_back('{addr: IMEM_ADDR, due: cycle + int'($urandom_range(lat_max, lat_min))});
                grant_cnt++;
            end
            if (!INST_VALID) begin
                checkOutput("nop_when_invalid", INST, NOP);
            end else if (!STALL && !REDIRECT) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL sb_underflow: got INST_PC %h, expected no instruction", INST_PC);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("inst_pc", INST_PC, mon_e.pc);
                    checkOutput("inst", INST, mon_e.inst);
                    if (mon_e.pc == 32'h0 && last_pc == 32'hFFFF_FFFC) saw_wrap = 1;
                    last_pc = mon_e.pc;
                    n_consumed++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g0;
        int c0;
        int since_redir;
        RST = 1'b1; IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = 32'h0;
        STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0;

        // Reset state, then streaming with 1-cycle memory latency
        applyStimulus(1, 0, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 32'h0);
        @(negedge CLK);
        checkResetState();
        for (int k = 0; k < 12; k++) begin
            applyStimulus(0, 1, 0, 0, 32'h0);
            @(negedge CLK);
            if (k == 0) begin
                checkOutput("t1_first_addr", IMEM_ADDR, RESET_PC);
                checkOutput("t1_first_req", {31'd0, IMEM_REQ}, 32'd1);
            end
            if (k >= 2) begin
                checkOutput("t1_valid", {31'd0, INST_VALID}, 32'd1);
                checkOutput("t1_pc", INST_PC, RESET_PC + 32'(4 * (k - 2)));
            end
        end

        // Grant withheld: request stays up on a frozen address (twelve words granted so far)
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 0, 0, 32'h0);
            @(negedge CLK);
            checkOutput("t2_addr_frozen", IMEM_ADDR, 32'h30);
            if (k == 4) begin
                checkOutput("t2_req", {31'd0, IMEM_REQ}, 32'd1);
                checkOutput("t2_valid", {31'd0, INST_VALID}, 32'd0);
                checkOutput("t2_nop", INST, NOP);
            end
        end

        // Downstream stall mid-stream
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 0, 32'h0);
        g0 = grant_cnt;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 1, 0, 32'h0);
            @(negedge CLK);
            checkOutput("t3_hold_valid", {31'd0, INST_VALID}, 32'd1);
            checkOutput("t3_hold_pc", INST_PC, exp_q[0].pc);
        end
        checkOutput("t3_grants_le_depth", {31'd0, (grant_cnt - g0) <= FIFO_DEPTH}, 32'd1);
        for (int k = 0; k < 10; k++) applyStimulus(0, 1, 0, 0, 32'h0);

        // Redirect with several responses in flight (3-cycle memory)
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 8; k++) applyStimulus(0, 1, 0, 0, 32'h0);
        applyStimulus(0, 1, 0, 1, 32'h0000_0103);
        @(negedge CLK);
        checkOutput("t4_no_req_in_redirect", {31'd0, IMEM_REQ}, 32'd0);
        applyStimulus(0, 1, 0, 0, 32'h0);
        @(negedge CLK);
        checkOutput("t4_valid_after", {31'd0, INST_VALID}, 32'd0);
        checkOutput("t4_addr_after", IMEM_ADDR, 32'h0000_0100);
        for (int k = 0; k < 15; k++) applyStimulus(0, 1, 0, 0, 32'h0);

        // Redirect while stalled with a response arriving in the same cycle
        lat_min = 1; lat_max = 1;
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 0, 32'h0);
        applyStimulus(0, 1, 1, 1, 32'h0000_0200);
        applyStimulus(0, 1, 1, 0, 32'h0);
        @(negedge CLK);
        checkOutput("t5_flushed_valid", {31'd0, INST_VALID}, 32'd0);
        checkOutput("t5_flushed_nop", INST, NOP);
        c0 = n_consumed;
        for (int k = 0; k < 8; k++) applyStimulus(0, 1, 0, 0, 32'h0);
        checkOutput("t5_progress", {31'd0, n_consumed > c0}, 32'd1);

        // Redirect to the top of the address space
        applyStimulus(0, 1, 0, 1, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 0, 0, 32'h0);
        @(negedge CLK);
        checkOutput("t6_addr", IMEM_ADDR, 32'hFFFF_FFFC);
        for (int k = 0; k < 10; k++) applyStimulus(0, 1, 0, 0, 32'h0);
        checkOutput("t6_wrap_seen", {31'd0, saw_wrap}, 32'd1);

        // Randomised traffic with a mid-run reset
        lat_min = 1; lat_max = 4;
        since_redir = 0;
        for (int i = 0; i < 2000; i++) begin
            bit r_rst;
            bit r_redir;
            r_rst   = (i == 1000) || (i == 1001);
            r_redir = !r_rst && (($urandom_range(99, 0) < 3) || (since_redir > 200));
            applyStimulus(r_rst, $urandom_range(99, 0) < 70, $urandom_range(99, 0) < 20, r_redir, $urandom);
            since_redir = (r_redir || r_rst) ? 0 : since_redir + 1;
            if (i == 1001) begin
                @(negedge CLK);
                checkResetState();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
